// File: rtl/inv_gen_sub_key.sv
// AES-128 reverse key-schedule engine: takes the round-10 key and walks the
// schedule backwards, emitting round keys 10 down to 0, one every two cycles.
// Each step spends one cycle on the S-box lookup (SUB) and one on the word
// update (UPD), so the inverse cipher never needs a stored key table.
module inv_gen_sub_key #(
  parameter int KEY_LEN    = 128,
  parameter int WORD_LEN   = 32,
  parameter int NUM_ROUNDS = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [KEY_LEN-1:0] data_in,
  output logic               ready,
  output logic [KEY_LEN-1:0] data_out,
  output logic [3:0]         round_out,
  output logic               valid_out,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SUB, UPD} state_t;

  // Forward AES S-box; read through a register so it maps onto block RAM/ROM.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x^-1 in GF(2^8): steps the round constant backwards (36, 1B, 80, ...).
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    logic [8:0] t;
    t = x[0] ? ({1'b0, x} ^ 9'h11B) : {1'b0, x};
    return t[8:1];
  endfunction

  state_t               state_reg, state_next;
  logic [KEY_LEN-1:0]   key_reg;
  logic [3:0]           round_reg;
  logic [7:0]           rcon_reg;
  logic [7:0]           sub_reg [4];
  logic [WORD_LEN-1:0]  w [4];
  logic [WORD_LEN-1:0]  t3, rot_word, sub_word;
  logic [KEY_LEN-1:0]   prev_key;

  // Split the current key into words, w[0] being the most significant.
  for (genvar gi = 0; gi < 4; gi++) begin : g_words
    assign w[gi] = key_reg[KEY_LEN-1-gi*WORD_LEN -: WORD_LEN];
  end

  // w3 of the previous round key is what went through SubWord(RotWord()).
  assign t3       = w[3] ^ w[2];
  assign rot_word = {t3[23:0], t3[31:24]};
  assign sub_word = {sub_reg[3], sub_reg[2], sub_reg[1], sub_reg[0]};

  // Words 1..3 of the previous key undo the forward chained XOR.
  assign prev_key[KEY_LEN-1 -: WORD_LEN] = w[0] ^ sub_word ^ {rcon_reg, 24'h0};
  for (genvar gi = 1; gi < 4; gi++) begin : g_prev
    assign prev_key[KEY_LEN-1-gi*WORD_LEN -: WORD_LEN] = w[gi] ^ w[gi-1];
  end

  assign ready = (state_reg == IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: IDLE -> SUB -> UPD -> SUB ... until round 0 is produced.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (valid_in) state_next = SUB;
      SUB:     state_next = UPD;
      UPD:     state_next = (round_reg == 4'd1) ? IDLE : SUB;
      default: state_next = IDLE;
    endcase
  end

  // Four parallel S-box lookups with a registered read, captured in SUB.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset)                  sub_reg[i] <= 8'h00;
      else if (state_reg == SUB)  sub_reg[i] <= SBOX[rot_word[8*i +: 8]];
    end
  end

  // Key/round/rcon bookkeeping and registered outputs; pulses default low.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg   <= '0;
      round_reg <= 4'd0;
      rcon_reg  <= 8'h00;
      data_out  <= '0;
      round_out <= 4'd0;
      valid_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      done      <= 1'b0;
      case (state_reg)
        IDLE: if (valid_in) begin
          key_reg   <= data_in;
          round_reg <= 4'(NUM_ROUNDS);
          rcon_reg  <= 8'h36;
          data_out  <= data_in;
          round_out <= 4'(NUM_ROUNDS);
          valid_out <= 1'b1;
        end
        UPD: begin
          key_reg   <= prev_key;
          data_out  <= prev_key;
          round_reg <= round_reg - 4'd1;
          round_out <= round_reg - 4'd1;
          valid_out <= 1'b1;
          rcon_reg  <= inv_xtime(rcon_reg);
          if (round_reg == 4'd1) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_gen_sub_key.sv
// Directed and randomised bench for the reverse AES-128 key schedule.
// Reference values come from FIPS-197 A.1 and a forward key expansion built
// on an S-box computed from GF(2^8) arithmetic.
module tb_inv_gen_sub_key;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic [127:0] data_in;
  logic         ready;
  logic [127:0] data_out;
  logic [3:0]   round_out;
  logic         valid_out;
  logic         done;

  inv_gen_sub_key dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready(ready), .data_out(data_out), .round_out(round_out),
    .valid_out(valid_out), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  int checks = 0;
  int errors = 0;
  logic [7:0]   sb [256];
  logic [127:0] got [11];
  logic [127:0] ref1 [11];
  logic [127:0] exp_rk [11];
  int npulse, ndone, done_cyc, pat_err, rdy_err, hold_err;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] x);
    logic [31:0] r;
    r = {x[23:0], x[31:24]};
    return {sb[r[31:24]], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]};
  endfunction

  // Forward expansion from a round-0 key into exp_rk[0..10].
  task automatic fwd_expand(input logic [127:0] k0);
    logic [31:0] a, b, c, d;
    logic [7:0]  rc;
    exp_rk[0] = k0; rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      a = exp_rk[r-1][127:96]; b = exp_rk[r-1][95:64];
      c = exp_rk[r-1][63:32];  d = exp_rk[r-1][31:0];
      a = a ^ subrot(d) ^ {rc, 24'h0};
      b = b ^ a; c = c ^ b; d = d ^ c;
      exp_rk[r] = {a, b, c, d};
      rc = xt(rc);
    end
  endtask

  // Backward expansion from a round-10 key into exp_rk[10..0].
  task automatic inv_expand(input logic [127:0] k10);
    logic [31:0] a, b, c, d;
    logic [7:0]  rc;
    exp_rk[10] = k10;
    for (int r = 10; r >= 1; r--) begin
      rc = 8'h01;
      for (int i = 1; i < r; i++) rc = xt(rc);
      a = exp_rk[r][127:96]; b = exp_rk[r][95:64];
      c = exp_rk[r][63:32];  d = exp_rk[r][31:0];
      d = d ^ c; c = c ^ b; b = b ^ a;
      a = a ^ subrot(d) ^ {rc, 24'h0};
      exp_rk[r-1] = {a, b, c, d};
    end
  endtask

  // Observe cycles 1..21 of a sequence whose start was driven before the call.
  task automatic collect(input bit busy_poke);
    logic [127:0] last;
    int idx;
    npulse = 0; ndone = 0; done_cyc = -1; pat_err = 0; rdy_err = 0; hold_err = 0;
    last = 'x;
    for (int r = 0; r < 11; r++) got[r] = 'x;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      valid_in = busy_poke && (c == 5);
      if (busy_poke && c == 5) data_in = '1;
      if (valid_out !== ((c % 2) == 1)) pat_err++;
      if (ready !== (c == 21)) rdy_err++;
      if (valid_out === 1'b1) begin
        npulse++;
        idx = int'(round_out);
        if (idx <= 10) got[idx] = data_out;
      end else if (data_out !== last) begin
        hold_err++;
      end
      last = data_out;
      if (done === 1'b1) begin ndone++; done_cyc = c; end
    end
  endtask

  task automatic check_shape(input string tag);
    check({tag, "_pulses"},   128'(npulse),   128'd11);
    check({tag, "_done_cnt"}, 128'(ndone),    128'd1);
    check({tag, "_done_cyc"}, 128'(done_cyc), 128'd21);
    check({tag, "_pattern"},  128'(pat_err),  128'd0);
    check({tag, "_ready"},    128'(rdy_err),  128'd0);
    check({tag, "_hold"},     128'(hold_err), 128'd0);
  endtask

  initial begin
    int bad;
    int stray;
    logic [127:0] k0;

    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));

    reset = 1'b1; valid_in = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_out",  data_out,          128'd0);
    check("rst_round_out", 128'(round_out),   128'd0);
    check("rst_valid_out", 128'(valid_out),   128'd0);
    check("rst_done",      128'(done),        128'd0);
    check("rst_ready",     128'(ready),       128'd1);
    reset = 1'b0;

    // FIPS-197 A.1 sequence.
    valid_in = 1'b1; data_in = K10;
    collect(1'b0);
    check("fips_r10", got[10], K10);
    check("fips_r9",  got[9],  K9);
    check("fips_r1",  got[1],  K1);
    check("fips_r0",  got[0],  K0);
    check_shape("fips");
    for (int r = 0; r < 11; r++) ref1[r] = got[r];
    $display("txn fips: r10=%h r0=%h pulses=%0d", got[10], got[0], npulse);

    // Back-to-back start of the all-zero key in cycle 21.
    valid_in = 1'b1; data_in = '0;
    collect(1'b0);
    inv_expand(128'd0);
    check("b2b_r10", got[10], 128'd0);
    check("b2b_r0",  got[0],  exp_rk[0]);
    check_shape("b2b");
    $display("txn b2b zero key: r0=%h", got[0]);

    // Busy rejection: all-ones start request in cycle 5 must be ignored.
    valid_in = 1'b1; data_in = K10;
    collect(1'b1);
    for (int r = 0; r < 11; r++) check($sformatf("busy_r%0d", r), got[r], ref1[r]);
    check_shape("busy");
    $display("txn busy rejection: r0=%h", got[0]);

    // Reset in cycle 8, together with an ignored start request.
    valid_in = 1'b1; data_in = K10;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
    reset = 1'b1; valid_in = 1'b1; data_in = '1;
    @(negedge clk);
    check("mrst_valid_out", 128'(valid_out), 128'd0);
    check("mrst_done",      128'(done),      128'd0);
    check("mrst_data_out",  data_out,        128'd0);
    check("mrst_round_out", 128'(round_out), 128'd0);
    check("mrst_ready",     128'(ready),     128'd1);
    reset = 1'b0; valid_in = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (valid_out !== 1'b0 || done !== 1'b0) stray++;
    end
    check("mrst_no_pulses", 128'(stray), 128'd0);
    valid_in = 1'b1; data_in = K10;
    collect(1'b0);
    for (int r = 0; r < 11; r++) check($sformatf("mrst_rerun_r%0d", r), got[r], ref1[r]);
    check_shape("mrst_rerun");
    $display("txn reset mid-sequence + restart: r0=%h", got[0]);

    // Random keys, launched back to back.
    for (int k = 0; k < 200; k++) begin
      k0 = {$urandom, $urandom, $urandom, $urandom};
      fwd_expand(k0);
      valid_in = 1'b1; data_in = exp_rk[10];
      collect(1'b0);
      bad = -1;
      for (int r = 10; r >= 0; r--) if (bad < 0 && got[r] !== exp_rk[r]) bad = r;
      if (bad < 0) bad = 0;
      check($sformatf("rand%0d_r%0d", k, bad), got[bad], exp_rk[bad]);
      check($sformatf("rand%0d_pulses", k), 128'(npulse + 100 * ndone + 1000 * pat_err), 128'd111);
      $display("txn rand %0d: k10=%h k0=%h", k, exp_rk[10], got[0]);
    end

    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
